// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion: one 32-bit schedule word per clock into a
// register store, with a combinational indexed 128-bit round-key read port.

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the AES affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        logic [7:0] b;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int k = 1; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        b = acc;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign out_byte = sbox_calc(in_byte);
endmodule

module aes_key_schedule_seq #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                done,
    output logic                ready,
    input  logic [3:0]          rk_idx,
    output logic [127:0]        rk_out
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW);

    localparam logic [IW-1:0] NK_W   = IW'(NK);
    localparam logic [IW-1:0] LAST_W = IW'(NW - 1);
    localparam logic [2:0]    P_LAST = 3'(NK - 1);
    localparam logic [3:0]    NR_W   = 4'(NR);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [2:0]    p_q, p_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          done_q, done_d;
    logic [31:0]   store_q [NW];
    logic [31:0]   store_d [NW];

    logic [IW-1:0] prev_idx, back_idx, rk_base;
    logic [31:0]   w_prev, w_back, sub_in, sub_out, temp, w_new;

    assign prev_idx = i_q - {{(IW-1){1'b0}}, 1'b1};
    assign back_idx = i_q - NK_W;
    assign w_prev   = store_q[prev_idx];
    assign w_back   = store_q[back_idx];

    // The same four S-boxes serve both the RotWord path (p==0) and the AES-256 mid-key path.
    assign sub_in = (p_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .in_byte  (sub_in[8*gi +: 8]),
                .out_byte (sub_out[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        temp = w_prev;
        if (p_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && p_q == 3'd4) begin
            temp = sub_out;
        end
    end

    assign w_new = w_back ^ temp;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        p_d     = p_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        store_d = store_q;
        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    for (int k = 0; k < NK; k++) begin
                        store_d[k] = key_in[KEY_BITS-1-32*k -: 32];
                    end
                    i_d     = NK_W;
                    p_d     = 3'd0;
                    rcon_d  = 8'h01;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                store_d[i_q] = w_new;
                i_d = i_q + {{(IW-1){1'b0}}, 1'b1};
                p_d = (p_q == P_LAST) ? 3'd0 : p_q + 3'd1;
                if (p_q == 3'd0) begin
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
                if (i_q == LAST_W) begin
                    state_d = READY;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            p_q     <= 3'd0;
            rcon_q  <= 8'h00;
            done_q  <= 1'b0;
            for (int k = 0; k < NW; k++) begin
                store_q[k] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            p_q     <= p_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
            for (int k = 0; k < NW; k++) begin
                store_q[k] <= store_d[k];
            end
        end
    end

    assign busy    = (state_q == EXPAND);
    assign ready   = (state_q == READY);
    assign done    = done_q;
    assign rk_base = {rk_idx, 2'b00};

    always_comb begin
        rk_out = 128'h0;
        if (ready && rk_idx <= NR_W) begin
            rk_out = {store_q[rk_base],
                      store_q[rk_base + {{(IW-2){1'b0}}, 2'd1}],
                      store_q[rk_base + {{(IW-2){1'b0}}, 2'd2}],
                      store_q[rk_base + {{(IW-2){1'b0}}, 2'd3}]};
        end
    end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq: FIPS-197 vectors for all three key sizes,
// held start, asynchronous reset mid-run and restart from READY.
module tb_aes_key_schedule_seq;
    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] KEY_192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] RK12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] KEY_256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         s128 = 1'b0, busy128, done128, ready128;
    logic [127:0] k128 = '0;
    logic [3:0]   idx128 = 4'd0;
    logic [127:0] rk128;

    logic         s192 = 1'b0, busy192, done192, ready192;
    logic [191:0] k192 = '0;
    logic [3:0]   idx192 = 4'd0;
    logic [127:0] rk192;

    logic         s256 = 1'b0, busy256, done256, ready256;
    logic [255:0] k256 = '0;
    logic [3:0]   idx256 = 4'd0;
    logic [127:0] rk256;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    aes_key_schedule_seq #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .start(s128), .key_in(k128), .busy(busy128),
        .done(done128), .ready(ready128), .rk_idx(idx128), .rk_out(rk128)
    );
    aes_key_schedule_seq #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst_n(rst_n), .start(s192), .key_in(k192), .busy(busy192),
        .done(done192), .ready(ready192), .rk_idx(idx192), .rk_out(rk192)
    );
    aes_key_schedule_seq #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .start(s256), .key_in(k256), .busy(busy256),
        .done(done256), .ready(ready256), .rk_idx(idx256), .rk_out(rk256)
    );

    task automatic run128(input logic [127:0] key, output int cyc);
        k128 = key;
        s128 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s128 = 1'b0;
        cyc = 1;
        while (!ready128 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (busy128 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy128); end
        total++; if (ready128 !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", ready128); end
        total++; if (done128 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done128); end
        total++; if (rk128 !== 128'h0) begin bad++; $display("FAIL reset_rk: got %h expected 0", rk128); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_aes128();
        int cyc;
        run128(KEY_A1, cyc);
        total++; if (cyc !== 41) begin bad++; $display("FAIL aes128_latency: got %0d expected 41", cyc); end
        total++; if (done128 !== 1'b1) begin bad++; $display("FAIL aes128_done: got %b expected 1", done128); end
        idx128 = 4'd0; #1;
        total++; if (rk128 !== KEY_A1) begin bad++; $display("FAIL aes128_rk0: got %h expected %h", rk128, KEY_A1); end
        idx128 = 4'd1; #1;
        total++; if (rk128 !== RK1_A1) begin bad++; $display("FAIL aes128_rk1: got %h expected %h", rk128, RK1_A1); end
        idx128 = 4'd10; #1;
        total++; if (rk128 !== RK10_A1) begin bad++; $display("FAIL aes128_rk10: got %h expected %h", rk128, RK10_A1); end
        idx128 = 4'd11; #1;
        total++; if (rk128 !== 128'h0) begin bad++; $display("FAIL aes128_rk11: got %h expected 0", rk128); end
        @(posedge clk);
        @(negedge clk);
        total++; if (done128 !== 1'b0) begin bad++; $display("FAIL aes128_done_pulse: got %b expected 0", done128); end
        total++; if (ready128 !== 1'b1) begin bad++; $display("FAIL aes128_ready_hold: got %b expected 1", ready128); end
        $display("test_aes128: latency=%0d rk10=%h", cyc, RK10_A1);
    endtask

    task automatic test_aes192();
        int cyc;
        k192 = KEY_192;
        s192 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s192 = 1'b0;
        cyc = 1;
        while (!ready192 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc !== 47) begin bad++; $display("FAIL aes192_latency: got %0d expected 47", cyc); end
        idx192 = 4'd12; #1;
        total++; if (rk192 !== RK12_192) begin bad++; $display("FAIL aes192_rk12: got %h expected %h", rk192, RK12_192); end
        $display("test_aes192: latency=%0d", cyc);
    endtask

    task automatic test_aes256();
        int cyc;
        k256 = KEY_256;
        s256 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s256 = 1'b0;
        cyc = 1;
        while (!ready256 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc !== 53) begin bad++; $display("FAIL aes256_latency: got %0d expected 53", cyc); end
        idx256 = 4'd14; #1;
        total++; if (rk256 !== RK14_256) begin bad++; $display("FAIL aes256_rk14: got %h expected %h", rk256, RK14_256); end
        idx256 = 4'd15; #1;
        total++; if (rk256 !== 128'h0) begin bad++; $display("FAIL aes256_rk15: got %h expected 0", rk256); end
        $display("test_aes256: latency=%0d", cyc);
    endtask

    task automatic test_start_held();
        int busy_cnt = 0;
        int gaps = 0;
        int n = 0;
        k128 = KEY_A1;
        s128 = 1'b1;
        while (n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (ready128) begin
                s128 = 1'b0;
                break;
            end
            if (busy128) busy_cnt++;
            else gaps++;
            if (n == 10) k128 = 128'h0;
        end
        total++; if (busy_cnt !== 40) begin bad++; $display("FAIL held_busy_count: got %0d expected 40", busy_cnt); end
        total++; if (gaps !== 0) begin bad++; $display("FAIL held_busy_gaps: got %0d expected 0", gaps); end
        idx128 = 4'd0; #1;
        total++; if (rk128 !== KEY_A1) begin bad++; $display("FAIL held_rk0: got %h expected %h", rk128, KEY_A1); end
        idx128 = 4'd10; #1;
        total++; if (rk128 !== RK10_A1) begin bad++; $display("FAIL held_rk10: got %h expected %h", rk128, RK10_A1); end
        $display("test_start_held: busy cycles=%0d", busy_cnt);
    endtask

    task automatic test_reset_mid_expand();
        int cyc;
        k128 = KEY_C1;
        s128 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s128 = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++; if (busy128 !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b expected 1", busy128); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy128 !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b expected 0", busy128); end
        total++; if (ready128 !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b expected 0", ready128); end
        total++; if (done128 !== 1'b0) begin bad++; $display("FAIL mid_rst_done: got %b expected 0", done128); end
        total++; if (rk128 !== 128'h0) begin bad++; $display("FAIL mid_rst_rk: got %h expected 0", rk128); end
        @(negedge clk);
        rst_n = 1'b1;
        idx128 = 4'd0; #1;
        total++; if (rk128 !== 128'h0) begin bad++; $display("FAIL mid_after_rk0: got %h expected 0", rk128); end
        @(negedge clk);
        run128(KEY_A1, cyc);
        total++; if (cyc !== 41) begin bad++; $display("FAIL mid_rerun_latency: got %0d expected 41", cyc); end
        idx128 = 4'd10; #1;
        total++; if (rk128 !== RK10_A1) begin bad++; $display("FAIL mid_rerun_rk10: got %h expected %h", rk128, RK10_A1); end
        $display("test_reset_mid_expand: rerun latency=%0d", cyc);
    endtask

    task automatic test_restart_from_ready();
        int cyc;
        idx128 = 4'd15; #1;
        total++; if (rk128 !== 128'h0) begin bad++; $display("FAIL restart_rk15: got %h expected 0", rk128); end
        @(negedge clk);
        k128 = KEY_C1;
        s128 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s128 = 1'b0;
        total++; if (ready128 !== 1'b0) begin bad++; $display("FAIL restart_ready_drop: got %b expected 0", ready128); end
        total++; if (busy128 !== 1'b1) begin bad++; $display("FAIL restart_busy_rise: got %b expected 1", busy128); end
        cyc = 1;
        while (!ready128 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc !== 41) begin bad++; $display("FAIL restart_latency: got %0d expected 41", cyc); end
        idx128 = 4'd10; #1;
        total++; if (rk128 !== RK10_C1) begin bad++; $display("FAIL restart_rk10: got %h expected %h", rk128, RK10_C1); end
        $display("test_restart_from_ready: latency=%0d", cyc);
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        @(negedge clk);
        test_start_held();
        @(negedge clk);
        test_reset_mid_expand();
        test_restart_from_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
